retire_trace_buffer: RTL
========================

// Module: retire_trace_buffer
// PURPOSE
//  Downstream of single_cycle_top: captures one record per retired instruction (PC, instr, write-back,
//  store) into a FIFO and drains it over valid/ready to a trace sink (bench logger or debug UART).
//  Detects program termination in hardware (self-loop, null instr, PC limit) and freezes capture.
//  Replaces ad-hoc per-cycle polling of core internals with a cycle-stamped, lossless-or-flagged trace.
// PARAMETERS
//  DEPTH     16          FIFO entries; power of 2, >=2
//  PC_LIMIT  32'h200     retire PC >= this is a halt condition
//  CYC_W     32          width of cycle stamp and counters
// PORTS
//  clk        in   1      core clock
//  rst        in   1      synchronous, active-high reset
//  ret_valid  in   1      instruction retires this cycle (tied 1 on single-cycle core)
//  ret_pc     in   32     PC of retiring instruction
//  ret_instr  in   32     instruction word
//  ret_we     in   1      RegWrite
//  ret_rd     in   5      destination register
//  ret_wdata  in   32     write-back Result
//  ret_st     in   1      MemWrite
//  ret_addr   in   32     ALUResult (store address)
//  ret_sdata  in   32     RD2 (store data)
//  out_valid  out  1      record available
//  out_ready  in   1      sink accepts record
//  out_cycle  out  CYC_W  cycle stamp of record
//  out_pc     out  32     recorded PC
//  out_instr  out  32     recorded instr
//  out_we     out  1      ret_we && ret_rd!=0
//  out_rd     out  5      ret_rd if out_we else 0
//  out_data   out  32     wdata if out_we; sdata if out_st; else 0
//  out_st     out  1      store flag
//  out_addr   out  32     store address if out_st else 0
//  halted     out  1      FSM in HALTED
//  overflow   out  1      sticky: a record was dropped
//  drop_cnt   out  CYC_W  dropped records (saturating)
// BEHAVIOUR
//  Reset: all outputs 0, FIFO empty, cycle counter 0, FSM=RUN. Reset mid-drain discards FIFO contents.
//  Cycle counter: +1 every clock while FSM=RUN; stamp = counter value in cycle of capture.
//  Push: ret_valid && FSM=RUN && (!full || pop). Pop: out_valid && out_ready. Push+pop same cycle
//   always legal, count unchanged; push when full with pop is accepted.
//  Drop: ret_valid && RUN && full && !pop -> no write, overflow<=1, drop_cnt+1 (saturate at all-ones).
//  Output is registered FIFO head: record visible on out_* 1 cycle after push into empty FIFO.
//   out_* hold stable while out_valid && !out_ready.
//  Pointers: log2(DEPTH) bits plus wrap bit; full = ptrs equal except wrap bit; wrap at DEPTH-1 -> 0.
//  Halt condition on a pushed-or-dropped record: instr==32'h00000063 || instr==0 || pc>=PC_LIMIT.
//   Record causing halt is itself captured (if space).
//  FSM: RUN --halt cond--> DRAIN; DRAIN --FIFO empty--> HALTED; HALTED stays until rst.
//   DRAIN/HALTED: ret_valid ignored, no drop counting, counter frozen; pops continue.
//  halted=1 only in HALTED (i.e. all records delivered).
// TESTING
//  1 ADDI x1,x0,5 @PC0 then BEQ x0,x0,0 @PC4, out_ready=1 -> 2 records: (cyc0,pc0,we,rd1,0x5),
//    (cyc1,pc4,0x00000063,we0); halted=1 after 2nd record popped.
//  2 SW x1,8(x0) with x1=0x5 -> out_st=1, out_addr=0x8, out_data=0x5, out_we=0, out_rd=0.
//  3 out_ready=0, 20 retires, DEPTH=16 -> 16 stored, overflow=1, drop_cnt=4; release ready -> 16
//    records with stamps 0..15 in order.
//  4 FIFO full, out_ready=1 with ret_valid=1 each cycle -> no drops, count stays 16, stamps contiguous.
//  5 ret_pc=0x200 -> captured, FSM DRAIN, later retires ignored; halted after FIFO drains.
//  6 rst asserted mid-DRAIN with 5 queued -> next cycle out_valid=0, halted=0, drop_cnt=0, FSM=RUN.

Source files
------------

// File: rtl/retire_trace_buffer_if.sv
// Retire-side record inputs and trace-sink stream for retire_trace_buffer.
// The master drives retirements and accepts records; the slave is the buffer.
interface retire_trace_buffer_if #(
  parameter int CYC_W = 32
);
  logic             ret_valid;
  logic [31:0]      ret_pc;
  logic [31:0]      ret_instr;
  logic             ret_we;
  logic [4:0]       ret_rd;
  logic [31:0]      ret_wdata;
  logic             ret_st;
  logic [31:0]      ret_addr;
  logic [31:0]      ret_sdata;

  logic             out_valid;
  logic             out_ready;
  logic [CYC_W-1:0] out_cycle;
  logic [31:0]      out_pc;
  logic [31:0]      out_instr;
  logic             out_we;
  logic [4:0]       out_rd;
  logic [31:0]      out_data;
  logic             out_st;
  logic [31:0]      out_addr;

  modport master (
    output ret_valid, ret_pc, ret_instr, ret_we, ret_rd, ret_wdata,
           ret_st, ret_addr, ret_sdata, out_ready,
    input  out_valid, out_cycle, out_pc, out_instr, out_we, out_rd,
           out_data, out_st, out_addr
  );

  modport slave (
    input  ret_valid, ret_pc, ret_instr, ret_we, ret_rd, ret_wdata,
           ret_st, ret_addr, ret_sdata, out_ready,
    output out_valid, out_cycle, out_pc, out_instr, out_we, out_rd,
           out_data, out_st, out_addr
  );
endinterface

// File: rtl/retire_trace_buffer.sv
// Captures one cycle-stamped record per retired instruction into a FIFO and
// drains it over valid/ready; detects program end and freezes capture.
//
//   state   | meaning
//   --------+----------------------------------------------------------
//   S_RUN   | capturing retirements, cycle counter running
//   S_DRAIN | halt seen; capture frozen, remaining records still drain
//   S_HALTED| FIFO empty after halt; stays until rst
module retire_trace_buffer #(
  parameter int          DEPTH    = 16,
  parameter logic [31:0] PC_LIMIT = 32'h200,
  parameter int          CYC_W    = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  retire_trace_buffer_if.slave  bus,
  output logic                  halted,
  output logic                  overflow,
  output logic [CYC_W-1:0]      drop_cnt
);

  localparam int PTR_W = $clog2(DEPTH);

  localparam logic [1:0] S_RUN    = 2'd0;
  localparam logic [1:0] S_DRAIN  = 2'd1;
  localparam logic [1:0] S_HALTED = 2'd2;

  typedef struct packed {
    logic [CYC_W-1:0] cycle;
    logic [31:0]      pc;
    logic [31:0]      instr;
    logic             we;
    logic [4:0]       rd;
    logic [31:0]      data;
    logic             st;
    logic [31:0]      addr;
  } rec_t;

  rec_t             mem [DEPTH];
  rec_t             rec_in;
  rec_t             head;
  logic [PTR_W:0]   wr_ptr;
  logic [PTR_W:0]   rd_ptr;
  logic [1:0]       state;
  logic [CYC_W-1:0] cyc_cnt;
  logic             empty;
  logic             full;
  logic             capture;
  logic             push;
  logic             pop;
  logic             drop;
  logic             halt_cond;
  logic             we_eff;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                 (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);

  assign capture = bus.ret_valid && (state == S_RUN);
  assign pop     = !empty && bus.out_ready;
  assign push    = capture && (!full || pop);
  assign drop    = capture && full && !pop;

  assign halt_cond = (bus.ret_instr == 32'h0000_0063) ||
                     (bus.ret_instr == 32'h0000_0000) ||
                     (bus.ret_pc >= PC_LIMIT);

  // x0 writes are architecturally invisible, so they are not reported.
  assign we_eff = bus.ret_we && (bus.ret_rd != 5'd0);

  always_comb begin
    rec_in       = '0;
    rec_in.cycle = cyc_cnt;
    rec_in.pc    = bus.ret_pc;
    rec_in.instr = bus.ret_instr;
    rec_in.we    = we_eff;
    rec_in.rd    = we_eff ? bus.ret_rd : 5'd0;
    rec_in.st    = bus.ret_st;
    rec_in.addr  = bus.ret_st ? bus.ret_addr : 32'd0;
    if (we_eff)
      rec_in.data = bus.ret_wdata;
    else if (bus.ret_st)
      rec_in.data = bus.ret_sdata;
  end

  // A full FIFO that pops in the same cycle writes into the slot being freed.
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr[PTR_W-1:0]] <= rec_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      state    <= S_RUN;
      cyc_cnt  <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + (PTR_W+1)'(1);
      if (pop)
        rd_ptr <= rd_ptr + (PTR_W+1)'(1);
      if (state == S_RUN)
        cyc_cnt <= cyc_cnt + CYC_W'(1);
      if (drop) begin
        overflow <= 1'b1;
        if (drop_cnt != '1)
          drop_cnt <= drop_cnt + CYC_W'(1);
      end
      case (state)
        S_RUN:    if (capture && halt_cond) state <= S_DRAIN;
        S_DRAIN:  if (empty) state <= S_HALTED;
        S_HALTED: state <= S_HALTED;
        default:  state <= S_RUN;
      endcase
    end
  end

  always_comb begin
    head = '0;
    if (!empty)
      head = mem[rd_ptr[PTR_W-1:0]];
  end

  assign bus.out_valid = !empty;
  assign bus.out_cycle = head.cycle;
  assign bus.out_pc    = head.pc;
  assign bus.out_instr = head.instr;
  assign bus.out_we    = head.we;
  assign bus.out_rd    = head.rd;
  assign bus.out_data  = head.data;
  assign bus.out_st    = head.st;
  assign bus.out_addr  = head.addr;

  assign halted = (state == S_HALTED);

endmodule
